// File: rtl/or_nway_accum.sv
// Streaming bitwise-OR reducer: pairwise a|b per beat, or an OR-fold
// of a frame of up to MAX_WORDS beats, behind valid/ready handshakes.
module or_nway_accum #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  localparam logic [CNT_W-1:0] MAXW = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_cnt;
  logic [WIDTH-1:0] ab;

  // Next-state, accumulator update and result-load decision.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    load      = 1'b0;
    load_data = '0;
    load_cnt  = '0;
    ab        = a | b;
    in_ready  = (state != EMIT) &&
                (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!mode) begin
            load      = 1'b1;
            load_data = ab;
            load_cnt  = ONE;
          end else begin
            acc_n = ab;
            cnt_n = ONE;
            if (in_last || MAX_WORDS == 1)
              state_n = EMIT;
            else
              state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = acc | ab;
          cnt_n = cnt + ONE;
          if (in_last || cnt_n == MAXW)
            state_n = EMIT;
        end
      end
      EMIT: begin
        if (!out_valid || out_ready) begin
          load      = 1'b1;
          load_data = acc;
          load_cnt  = cnt;
          acc_n     = '0;
          cnt_n     = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, accumulator and output register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_any   <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_any   <= |load_data;
        out_count <= load_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_or_nway_accum.sv
// Self-checking bench for or_nway_accum: vector table, directed
// multi-cycle sequences and random traffic against a frame-level model.
module tb_or_nway_accum;
  localparam int W  = 16;
  localparam int MW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_any;
  logic [CW-1:0] out_count;

  or_nway_accum #(
    .WIDTH(W),
    .MAX_WORDS(MW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_any(out_any),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: queue of finished results plus one open frame
  logic [W-1:0] q_data[$];
  int           q_cnt[$];
  logic         m_open;
  logic [W-1:0] m_acc;
  int           m_cnt;
  int           n_results;
  logic [W-1:0] last_data;
  logic         last_any;
  int           last_cnt;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp;
    logic         exp_any;
  } vec_t;
  vec_t vecs[6];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    q_data.delete();
    q_cnt.delete();
    m_open = 1'b0;
    m_acc  = '0;
    m_cnt  = 0;
  endtask

  // called at a negedge with inputs already driven; returns at next negedge
  task automatic tick();
    logic [W-1:0] ed;
    int           ec;
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (out_valid && out_ready) begin
        n_results++;
        last_data = out_data;
        last_any  = out_any;
        last_cnt  = int'(out_count);
        if (q_data.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_result: got %0h expected none", out_data);
        end else begin
          ed = q_data.pop_front();
          ec = q_cnt.pop_front();
          check("sb_data", out_data, ed);
          check("sb_any", out_any, |ed);
          check("sb_count", out_count, ec);
        end
      end
      if (in_valid && in_ready) begin
        if (!m_open && !mode) begin
          q_data.push_back(a | b);
          q_cnt.push_back(1);
        end else begin
          if (!m_open) begin
            m_open = 1'b1;
            m_acc  = '0;
            m_cnt  = 0;
          end
          m_acc = m_acc | a | b;
          m_cnt++;
          if (in_last || m_cnt == MW) begin
            q_data.push_back(m_acc);
            q_cnt.push_back(m_cnt);
            m_open = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic md, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic lst);
    logic ok;
    ok = 1'b0;
    mode     = md;
    a        = va;
    b        = vb;
    in_last  = lst;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      ok = in_ready;
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int           n0;
    logic         hold;
    logic [W-1:0] hd;
    logic [CW-1:0] hc;

    model_clear();
    n_results = 0;
    last_data = '0;
    last_any  = 1'b0;
    last_cnt  = 0;
    vecs[0] = '{16'h00F0, 16'h0F00, 16'h0FF0, 1'b1};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 16'h8001, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 16'h5335, 1'b1};
    vecs[5] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b1};

    // T1 reset with a beat offered
    reset     = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b1;
    a         = 16'hFFFF;
    b         = 16'hFFFF;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_any", out_any, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);

    // T2 pairwise table, back-to-back
    out_ready = 1'b1;
    mode      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a        = vecs[i].va;
      b        = vecs[i].vb;
      in_valid = 1'b1;
      #1;
      check("pw_in_ready", in_ready, 1);
      tick();
      check("pw_valid", out_valid, 1);
      check("pw_data", out_data, vecs[i].exp);
      check("pw_any", out_any, vecs[i].exp_any);
      check("pw_count", out_count, 1);
    end
    idle(1);
    check("pw_drained", out_valid, 0);

    // T3 accumulate with last
    n0 = n_results;
    send(1'b1, 16'h0001, 16'h0000, 1'b0);
    check("acc_no_early", out_valid, 0);
    send(1'b1, 16'h0000, 16'h0010, 1'b0);
    send(1'b1, 16'h8000, 16'h0000, 1'b1);
    check("acc_latency_emit", out_valid, 0);
    idle(1);
    check("acc_valid", out_valid, 1);
    check("acc_data", out_data, 16'h8011);
    check("acc_count", out_count, 3);
    idle(3);
    check("acc_one_pulse", n_results - n0, 1);

    // T4 auto-close at MAX_WORDS
    n0 = n_results;
    for (int i = 0; i < 10; i++) send(1'b1, '0, '0, 1'b0);
    idle(5);
    check("auto_results", n_results - n0, 1);
    check("auto_data", last_data, 0);
    check("auto_any", last_any, 0);
    check("auto_count", last_cnt, 8);
    send(1'b0, '0, '0, 1'b1);
    idle(3);
    check("auto_tail_count", last_cnt, 3);
    check("auto_tail_results", n_results - n0, 2);

    // T5 backpressure then same-cycle accept and consume
    out_ready = 1'b0;
    send(1'b0, 16'h1234, 16'h0000, 1'b0);
    check("bp_valid", out_valid, 1);
    mode     = 1'b0;
    a        = 16'h00FF;
    b        = 16'h0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, 16'h1234);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 1);
    check("bp_new_data", out_data, 16'h00FF);
    idle(2);

    // T6 reset mid-frame
    send(1'b1, 16'h0100, 16'h0000, 1'b0);
    send(1'b1, 16'h0200, 16'h0000, 1'b0);
    n0 = n_results;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(4);
    check("rmf_no_result", n_results - n0, 0);
    check("rmf_valid", out_valid, 0);
    send(1'b1, 16'h0004, 16'h0000, 1'b1);
    idle(3);
    check("rmf_data", last_data, 16'h0004);
    check("rmf_count", last_cnt, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      hold      = out_valid && !out_ready;
      hd        = out_data;
      hc        = out_count;
      in_valid  = ($urandom % 4) != 0;
      mode      = $urandom % 2;
      in_last   = ($urandom % 5) == 0;
      out_ready = ($urandom % 4) != 0;
      a         = W'($urandom & $urandom);
      b         = W'($urandom & $urandom);
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_count", out_count, hc);
      end
      tick();
    end
    out_ready = 1'b1;
    idle(4);
    if (m_open) send(1'b1, '0, '0, 1'b1);
    idle(6);
    check("drain_queue_empty", q_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
